sha256_msg_schedule: RTL and testbench

Producer side of the SHA-256 round interface. It accepts one 512-bit message block and issues the load strobe for the round datapath. It then streams the 64 expanded message words W[t] and round constants K[t], one per cycle, into the compression round block. It is sequenced by a small FSM and signals completion so the hash wrapper can add the working variables back into H.

---
 rtl/sha256_msg_schedule.sv | 102 ++++++++++
 tb/tb_sha256_msg_schedule.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message scheduler: captures a 512-bit block, strobes the round
// datapath's hash load, then streams W[t]/K[t] for rounds 0..63.
//
// state | meaning
// IDLE  | waiting for start; block captured on start
// LOAD  | one-cycle load_hash strobe to compression
// RUN   | 64 round cycles, w_i/k_i valid
// DONE  | one-cycle completion pulse
module sha256_msg_schedule (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [511:0] block,
  output logic         load_hash,
  output logic         round_valid,
  output logic [5:0]   round,
  output logic [31:0]  w_i,
  output logic [31:0]  k_i,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [31:0] K_ROM [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_t      state, state_nxt;
  logic [31:0] win [16];
  logic [31:0] w_new;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (round == 6'd63) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Rounds 48..63 still expand; those words simply fall off the window unused.
  assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      round <= '0;
      for (int j = 0; j < 16; j++) win[j] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          round <= '0;
          for (int j = 0; j < 16; j++) win[j] <= block[511 - 32*j -: 32];
        end
        RUN: begin
          round <= round + 6'd1;
          for (int j = 0; j < 15; j++) win[j] <= win[j+1];
          win[15] <= w_new;
        end
        default: ;
      endcase
    end
  end

  assign load_hash   = (state == LOAD);
  assign round_valid = (state == RUN);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign w_i         = win[0];
  assign k_i         = K_ROM[round];

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Scoreboarded bench for sha256_msg_schedule: reference expansion per block,
// reference compression for the "abc" digest, and timing/protocol checks.
module tb_sha256_msg_schedule;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         start = 1'b0;
  logic [511:0] block = '0;
  logic         load_hash, round_valid, busy, done;
  logic [5:0]   round;
  logic [31:0]  w_i, k_i;

  sha256_msg_schedule dut (
    .clk(clk), .n_rst(n_rst), .start(start), .block(block),
    .load_hash(load_hash), .round_valid(round_valid), .round(round),
    .w_i(w_i), .k_i(k_i), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [511:0] ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};

  localparam logic [31:0] KT [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] H0 [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef struct {
    logic [5:0]  r;
    logic [31:0] w;
    logic [31:0] k;
  } exp_t;

  exp_t sq[$];
  int   done_q[$];
  int   checks = 0;
  int   errors = 0;
  int   load_cyc = 0;
  int   load_cnt = 0;
  logic abc_mode = 1'b0;
  logic [31:0] ca, cb, cc, cd, ce, cf, cg, chh;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_block(input logic [511:0] b);
    logic [31:0] w [64];
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int t = 0; t < 64; t++) sq.push_back('{6'(t), w[t], KT[t]});
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
    return b;
  endfunction

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_round(input logic [5:0] r, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (round_valid === 1'b1 && round === r) begin ok = 1'b1; break; end
    end
  endtask

  // Output monitor: scoreboard pops, latency, and a reference compression.
  initial begin
    exp_t e;
    logic [31:0] t1, t2;
    forever begin
      @(negedge clk);
      if (n_rst) begin
        if (load_hash || round_valid)
          check("lh_rv_exclusive", {31'b0, load_hash & round_valid}, 32'd0);
        if (load_hash) begin
          load_cyc = cyc;
          load_cnt++;
          {ca, cb, cc, cd, ce, cf, cg, chh} = {H0[0], H0[1], H0[2], H0[3], H0[4], H0[5], H0[6], H0[7]};
        end
        if (round_valid) begin
          if (sq.size() == 0) check("unexpected_round", 32'd1, 32'd0);
          else begin
            e = sq.pop_front();
            check("round_idx", {26'b0, round}, {26'b0, e.r});
            check("w_i", w_i, e.w);
            check("k_i", k_i, e.k);
          end
          if (round == 6'd0) check("round0_latency", 32'(cyc), 32'(load_cyc + 1));
          if (abc_mode) begin
            case (round)
              6'd0:  begin check("abc_w0", w_i, 32'h61626380); check("abc_k0", k_i, 32'h428a2f98); end
              6'd15: check("abc_w15", w_i, 32'h00000018);
              6'd16: check("abc_w16", w_i, 32'h61626380);
              6'd17: check("abc_w17", w_i, 32'h000f0000);
              6'd63: check("abc_k63", k_i, 32'hc67178f2);
              default: ;
            endcase
          end
          t1 = chh + (rotr(ce, 6) ^ rotr(ce, 11) ^ rotr(ce, 25)) + ((ce & cf) ^ (~ce & cg)) + k_i + w_i;
          t2 = (rotr(ca, 2) ^ rotr(ca, 13) ^ rotr(ca, 22)) + ((ca & cb) ^ (ca & cc) ^ (cb & cc));
          chh = cg; cg = cf; cf = ce; ce = cd + t1;
          cd = cc; cc = cb; cb = ca; ca = t1 + t2;
        end
        if (done) begin
          done_q.push_back(cyc);
          check("done_latency", 32'(cyc), 32'(load_cyc + 65));
          if (abc_mode) begin
            check("abc_a", ca, 32'h506e3058);
            check("abc_digest0", ca + H0[0], 32'hba7816bf);
          end
        end
      end
    end
  end

  initial begin
    bit ok;
    int nd, nl;
    logic [511:0] rb;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_load_hash", {31'b0, load_hash}, 32'd0);
    check("rst_round_valid", {31'b0, round_valid}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_round", {26'b0, round}, 32'd0);
    check("rst_w_i", w_i, 32'd0);
    check("rst_k_i", k_i, 32'h428a2f98);
    n_rst = 1'b1;
    @(negedge clk);

    // "abc" block, single start pulse
    abc_mode = 1'b1;
    block = ABC;
    push_block(ABC);
    nd = done_q.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    block = rand_block();
    check("abc_load_hash", {31'b0, load_hash}, 32'd1);
    check("abc_load_rv", {31'b0, round_valid}, 32'd0);
    wait_done(100, ok);
    check("abc_done_seen", {31'b0, ok}, 32'd1);
    @(negedge clk);
    check("abc_done_one_cycle", {31'b0, done}, 32'd0);
    check("abc_idle_busy", {31'b0, busy}, 32'd0);
    check("abc_done_count", 32'(done_q.size() - nd), 32'd1);
    check("abc_sq_empty", 32'(sq.size()), 32'd0);

    // Random block
    abc_mode = 1'b0;
    rb = rand_block();
    block = rb;
    push_block(rb);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100, ok);
    check("rand_done_seen", {31'b0, ok}, 32'd1);
    @(negedge clk);
    check("rand_sq_empty", 32'(sq.size()), 32'd0);

    // start pulses in LOAD, RUN(30) and DONE are ignored
    rb = rand_block();
    block = rb;
    push_block(rb);
    nd = done_q.size();
    nl = load_cnt;
    start = 1'b1;
    @(negedge clk);
    block = rand_block();
    @(negedge clk);
    start = 1'b0;
    wait_round(6'd30, 100, ok);
    check("ign_round30_seen", {31'b0, ok}, 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100, ok);
    check("ign_done_seen", {31'b0, ok}, 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("ign_busy", {31'b0, busy}, 32'd0);
    check("ign_done_count", 32'(done_q.size() - nd), 32'd1);
    check("ign_load_count", 32'(load_cnt - nl), 32'd1);
    check("ign_sq_empty", 32'(sq.size()), 32'd0);

    // Reset mid-RUN at round 20, then a full clean run
    rb = rand_block();
    block = rb;
    push_block(rb);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_round(6'd20, 100, ok);
    check("rst_round20_seen", {31'b0, ok}, 32'd1);
    #1 n_rst = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_round_valid", {31'b0, round_valid}, 32'd0);
    check("midrst_round", {26'b0, round}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_load_hash", {31'b0, load_hash}, 32'd0);
    sq.delete();
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    abc_mode = 1'b1;
    block = ABC;
    push_block(ABC);
    nd = done_q.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100, ok);
    check("postrst_done_seen", {31'b0, ok}, 32'd1);
    @(negedge clk);
    check("postrst_done_count", 32'(done_q.size() - nd), 32'd1);
    check("postrst_sq_empty", 32'(sq.size()), 32'd0);

    // start held for 200 cycles: three blocks, done pulses 67 cycles apart
    block = ABC;
    for (int i = 0; i < 3; i++) push_block(ABC);
    nd = done_q.size();
    start = 1'b1;
    repeat (200) @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("b2b_done_count", 32'(done_q.size() - nd), 32'd3);
    if (done_q.size() - nd == 3) begin
      check("b2b_gap1", 32'(done_q[nd+1] - done_q[nd]), 32'd67);
      check("b2b_gap2", 32'(done_q[nd+2] - done_q[nd+1]), 32'd67);
    end
    check("b2b_sq_empty", 32'(sq.size()), 32'd0);
    check("b2b_idle", {31'b0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
